// File: rtl/order_dispatcher_pkg.sv
// order_dispatcher_pkg
// Shared constants for the order dispatcher slice: cache opcodes, error codes,
// bus widths, and opcode-to-engine decode helpers.
package order_dispatcher_pkg;

   localparam int unsigned ORDER_W     = 3;
   localparam int unsigned COUNT_W     = 10;
   localparam int unsigned NUM_ENGINES = 4;

   // Opcodes delivered by the order cache
   localparam logic [ORDER_W-1:0] ORD_NONE  = 3'd0;
   localparam logic [ORDER_W-1:0] ORD_CONV  = 3'd1;
   localparam logic [ORDER_W-1:0] ORD_POOL  = 3'd2;
   localparam logic [ORDER_W-1:0] ORD_UPSMP = 3'd3;
   localparam logic [ORDER_W-1:0] ORD_ADD   = 3'd4;
   localparam logic [ORDER_W-1:0] ORD_END   = 3'd5;

   // Error codes reported while the dispatcher sits in its error state
   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
   localparam logic [1:0] ERR_PROTOCOL = 2'd3;

   // One-hot engine select for an opcode; zero for anything that is not an engine
   function automatic logic [NUM_ENGINES-1:0] engine_onehot(input logic [ORDER_W-1:0] op);
      case (op)
         ORD_CONV:  return 4'b0001;
         ORD_POOL:  return 4'b0010;
         ORD_UPSMP: return 4'b0100;
         ORD_ADD:   return 4'b1000;
         default:   return '0;
      endcase
   endfunction

   function automatic logic is_engine_order(input logic [ORDER_W-1:0] op);
      return |engine_onehot(op);
   endfunction

endpackage

// File: rtl/order_dispatcher_if.sv
// order_dispatcher_if
// Bundles the dispatcher's control, order-cache and engine handshakes.
//   task_start/abort            : task control requests
//   pop_order_en/calculate_start/order : order cache pop and returned opcode
//   engine_start/engine_done    : per-engine one-hot start and completion pulses
//   active_order/order_count/busy/task_done/task_error/error_code : status
// slave  = dispatcher side, master = host/cache/engine side.
interface order_dispatcher_if;
   import order_dispatcher_pkg::*;

   logic                   task_start;
   logic                   abort;
   logic                   pop_order_en;
   logic                   calculate_start;
   logic [ORDER_W-1:0]     order;
   logic [NUM_ENGINES-1:0] engine_start;
   logic [NUM_ENGINES-1:0] engine_done;
   logic [ORDER_W-1:0]     active_order;
   logic [COUNT_W-1:0]     order_count;
   logic                   busy;
   logic                   task_done;
   logic                   task_error;
   logic [1:0]             error_code;

   modport slave (
      input  task_start, abort, calculate_start, order, engine_done,
      output pop_order_en, engine_start, active_order, order_count,
             busy, task_done, task_error, error_code
   );

   modport master (
      output task_start, abort, calculate_start, order, engine_done,
      input  pop_order_en, engine_start, active_order, order_count,
             busy, task_done, task_error, error_code
   );

endinterface

// File: rtl/order_watchdog.sv
// order_watchdog
// Saturating cycle counter guarding a running engine.
//   system_clk : clock          rst       : synchronous active-high reset
//   clear_i    : zero the count enable_i  : count this cycle
//   expired_o  : high in the LIMIT-th enabled cycle since the last clear
module order_watchdog #(
   parameter int unsigned LIMIT = 24'hFF_FFFF
) (
   input  logic system_clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int unsigned CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge system_clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (enable_i && (cnt_q != CNT_W'(LIMIT)))
         cnt_d = cnt_q + 1'b1;
   end

   // cnt_q holds the number of enabled cycles already elapsed, so the LIMIT-th
   // enabled cycle sees LIMIT-1 and flags expiry within that same cycle.
   assign expired_o = enable_i && (cnt_q >= CNT_W'(LIMIT - 1));

endmodule

// File: rtl/order_dispatcher.sv
// order_dispatcher
// Walks the cached order list: pops an opcode, starts the matching engine,
// waits for its done pulse (under a watchdog), and repeats until the end order.
//   system_clk : clock           rst : synchronous active-high reset
//   bus        : order_dispatcher_if.slave (control, cache and engine handshakes)
module order_dispatcher
   import order_dispatcher_pkg::*;
#(
   parameter int unsigned MAX_ORDERS     = 512,
   parameter int unsigned TIMEOUT_CYCLES = 24'hFF_FFFF
) (
   input  logic              system_clk,
   input  logic              rst,
   order_dispatcher_if.slave bus
);

   typedef enum logic [2:0] {IDLE, POP, LOAD, ISSUE, RUN, FINISH, ERROR} state_e;

   state_e               state_q, state_d;
   logic [ORDER_W-1:0]   active_q, active_d;
   logic [COUNT_W-1:0]   count_q, count_d;
   logic [1:0]           err_q, err_d;

   logic                   wd_clear, wd_en, wd_expired;
   logic [NUM_ENGINES-1:0] eng_sel;

   order_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
      .system_clk (system_clk),
      .rst        (rst),
      .clear_i    (wd_clear),
      .enable_i   (wd_en),
      .expired_o  (wd_expired)
   );

   assign eng_sel = engine_onehot(active_q);

   always_ff @(posedge system_clk) begin
      if (rst) begin
         state_q  <= IDLE;
         active_q <= ORD_NONE;
         count_q  <= '0;
         err_q    <= ERR_NONE;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         count_q  <= count_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      active_d = active_q;
      count_d  = count_q;
      err_d    = err_q;
      wd_clear = 1'b0;
      wd_en    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.task_start && !bus.abort) begin
               state_d = POP;
               count_d = '0;
            end
         end
         POP: begin
            state_d = LOAD;
            if (count_q != '1) count_d = count_q + 1'b1;
         end
         LOAD: begin
            if (!bus.calculate_start) begin
               state_d = ERROR;
               err_d   = ERR_PROTOCOL;
            end else if (bus.order == ORD_END) begin
               state_d  = FINISH;
               active_d = ORD_NONE;
            end else if (is_engine_order(bus.order)) begin
               state_d  = ISSUE;
               active_d = bus.order;
            end else begin
               state_d = ERROR;
               err_d   = ERR_ILLEGAL;
            end
         end
         ISSUE: begin
            wd_clear = 1'b1;
            state_d  = RUN;
         end
         RUN: begin
            wd_en = 1'b1;
            // Only the engine that was started may complete the order
            if (|(bus.engine_done & eng_sel)) begin
               if (count_q == COUNT_W'(MAX_ORDERS)) begin
                  state_d = ERROR;
                  err_d   = ERR_PROTOCOL;
               end else begin
                  state_d = POP;
               end
            end else if (wd_expired) begin
               state_d = ERROR;
               err_d   = ERR_TIMEOUT;
            end
         end
         FINISH: state_d = IDLE;
         ERROR:  state_d = ERROR;
         default: state_d = IDLE;
      endcase

      // Abort overrides every transition above, including a same-cycle done
      if (bus.abort && (state_q != IDLE)) begin
         state_d  = IDLE;
         active_d = ORD_NONE;
         err_d    = ERR_NONE;
      end
   end

   assign bus.pop_order_en = (state_q == POP);
   assign bus.engine_start = (state_q == ISSUE) ? eng_sel : '0;
   assign bus.task_done    = (state_q == FINISH);
   assign bus.task_error   = (state_q == ERROR);
   assign bus.busy         = (state_q != IDLE) && (state_q != ERROR);
   assign bus.active_order = active_q;
   assign bus.order_count  = count_q;
   assign bus.error_code   = err_q;

endmodule

// File: tb/tb_order_dispatcher.sv
// tb_order_dispatcher
// Directed bench: behavioural order cache and engine models around the
// dispatcher, one task per scenario with hand-computed expectations.
module tb_order_dispatcher;
   import order_dispatcher_pkg::*;

   logic system_clk = 1'b0;
   logic rst        = 1'b1;
   always #5 system_clk = ~system_clk;

   order_dispatcher_if bus();

   order_dispatcher #(.MAX_ORDERS(4), .TIMEOUT_CYCLES(100)) dut (
      .system_clk (system_clk),
      .rst        (rst),
      .bus        (bus)
   );

   int vectors    = 0;
   int miscompares = 0;

   logic [2:0] list [0:7];
   logic [2:0] ptr;
   bit         cal_pending, suppress_cal;
   int         eng_delay, eng_cnt;
   logic [3:0] eng_bit;
   int         pops, done_cnt, cyc, start_cyc;
   logic [3:0] starts [$];

   // One clock: outputs observed at the falling edge, next inputs driven there
   task automatic tick();
      @(negedge system_clk);
      cyc++;
      bus.task_start      = 1'b0;
      bus.abort           = 1'b0;
      bus.calculate_start = 1'b0;
      bus.engine_done     = '0;
      if (cal_pending) begin
         bus.calculate_start = !suppress_cal;
         bus.order           = list[ptr];
         ptr                 = ptr + 3'd1;
         cal_pending         = 1'b0;
      end
      if (bus.pop_order_en) begin
         pops++;
         cal_pending = 1'b1;
      end
      if (eng_cnt > 0) begin
         eng_cnt--;
         if (eng_cnt == 0) bus.engine_done = eng_bit;
      end
      if (bus.engine_start != 4'b0000) begin
         starts.push_back(bus.engine_start);
         eng_bit   = bus.engine_start;
         eng_cnt   = eng_delay;
         start_cyc = cyc;
      end
      if (bus.task_done) done_cnt++;
   endtask

   task automatic prep(input logic [2:0] a, b, c, d, e, input int delay);
      list[0] = a; list[1] = b; list[2] = c; list[3] = d; list[4] = e;
      list[5] = 3'd0; list[6] = 3'd0; list[7] = 3'd0;
      ptr = 3'd0; cal_pending = 1'b0; suppress_cal = 1'b0;
      eng_delay = delay; eng_cnt = 0;
      pops = 0; done_cnt = 0;
      starts.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      vectors++; if (bus.pop_order_en !== 1'b0) begin miscompares++; $display("FAIL reset_pop: got %b want 0", bus.pop_order_en); end
      vectors++; if (bus.engine_start !== 4'b0000) begin miscompares++; $display("FAIL reset_engine_start: got %b want 0000", bus.engine_start); end
      vectors++; if (bus.task_done !== 1'b0) begin miscompares++; $display("FAIL reset_task_done: got %b want 0", bus.task_done); end
      vectors++; if (bus.task_error !== 1'b0) begin miscompares++; $display("FAIL reset_task_error: got %b want 0", bus.task_error); end
      vectors++; if (bus.error_code !== 2'd0) begin miscompares++; $display("FAIL reset_error_code: got %0d want 0", bus.error_code); end
      vectors++; if (bus.active_order !== 3'd0) begin miscompares++; $display("FAIL reset_active_order: got %0d want 0", bus.active_order); end
      vectors++; if (bus.order_count !== 10'd0) begin miscompares++; $display("FAIL reset_order_count: got %0d want 0", bus.order_count); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_list();
      int n;
      prep(3'd1, 3'd2, 3'd5, 3'd0, 3'd0, 10);
      bus.task_start = 1'b1;
      tick();
      vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_rise: got %b want 1", bus.busy); end
      vectors++; if (bus.pop_order_en !== 1'b1) begin miscompares++; $display("FAIL basic_first_pop: got %b want 1", bus.pop_order_en); end
      vectors++; if (bus.order_count !== 10'd0) begin miscompares++; $display("FAIL basic_count_in_pop: got %0d want 0", bus.order_count); end
      n = 0;
      while (starts.size() == 0 && n < 20) begin tick(); n++; end
      vectors++; if (starts.size() == 0) begin miscompares++; $display("FAIL basic_first_start_wait: got no start want start within 20 cycles"); end
      vectors++; if (bus.active_order !== 3'd1) begin miscompares++; $display("FAIL basic_active_order: got %0d want 1", bus.active_order); end
      n = 0;
      while (done_cnt == 0 && n < 200) begin tick(); n++; end
      vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL basic_task_done: got %0d pulses want 1", done_cnt); end
      vectors++; if (starts.size() != 2) begin miscompares++; $display("FAIL basic_start_count: got %0d want 2", starts.size()); end
      else begin
         vectors++; if (starts[0] !== 4'b0001) begin miscompares++; $display("FAIL basic_start0: got %b want 0001", starts[0]); end
         vectors++; if (starts[1] !== 4'b0010) begin miscompares++; $display("FAIL basic_start1: got %b want 0010", starts[1]); end
      end
      vectors++; if (pops != 3) begin miscompares++; $display("FAIL basic_pops: got %0d want 3", pops); end
      vectors++; if (bus.order_count !== 10'd3) begin miscompares++; $display("FAIL basic_order_count: got %0d want 3", bus.order_count); end
      vectors++; if (bus.active_order !== 3'd0) begin miscompares++; $display("FAIL basic_active_cleared: got %0d want 0", bus.active_order); end
      tick();
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL basic_idle_busy: got %b want 0", bus.busy); end
      vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL basic_single_done: got %0d want 1", done_cnt); end
   endtask

   task automatic test_illegal_opcode();
      int n;
      prep(3'd3, 3'd0, 3'd5, 3'd0, 3'd0, 10);
      bus.task_start = 1'b1;
      tick();
      n = 0;
      while (!bus.task_error && n < 100) begin tick(); n++; end
      vectors++; if (bus.task_error !== 1'b1) begin miscompares++; $display("FAIL illegal_error_wait: got %b want 1", bus.task_error); end
      vectors++; if (bus.error_code !== ERR_ILLEGAL) begin miscompares++; $display("FAIL illegal_code: got %0d want 1", bus.error_code); end
      vectors++; if (starts.size() != 1 || starts[0] !== 4'b0100) begin miscompares++; $display("FAIL illegal_starts: got %0d starts want one 0100", starts.size()); end
      bus.task_start = 1'b1;
      tick();
      repeat (5) tick();
      vectors++; if (pops != 2) begin miscompares++; $display("FAIL illegal_no_more_pops: got %0d want 2", pops); end
      vectors++; if (bus.task_error !== 1'b1 || bus.error_code !== 2'd1) begin miscompares++; $display("FAIL illegal_sticky: got err=%b code=%0d want 1/1", bus.task_error, bus.error_code); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL illegal_busy: got %b want 0", bus.busy); end
      bus.abort = 1'b1;
      tick();
      vectors++; if (bus.task_error !== 1'b0 || bus.error_code !== 2'd0) begin miscompares++; $display("FAIL illegal_abort_clear: got err=%b code=%0d want 0/0", bus.task_error, bus.error_code); end
   endtask

   task automatic test_timeout();
      int n;
      prep(3'd1, 3'd5, 3'd0, 3'd0, 3'd0, 0);
      bus.task_start = 1'b1;
      tick();
      n = 0;
      while (!bus.task_error && n < 300) begin tick(); n++; end
      vectors++; if (bus.task_error !== 1'b1) begin miscompares++; $display("FAIL timeout_error_wait: got %b want 1", bus.task_error); end
      vectors++; if (cyc - start_cyc != 101) begin miscompares++; $display("FAIL timeout_run_cycles: got %0d want 100", cyc - start_cyc - 1); end
      vectors++; if (bus.error_code !== ERR_TIMEOUT) begin miscompares++; $display("FAIL timeout_code: got %0d want 2", bus.error_code); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL timeout_busy: got %b want 0", bus.busy); end
      bus.abort = 1'b1;
      tick();
   endtask

   task automatic test_abort_race();
      int n;
      prep(3'd1, 3'd5, 3'd0, 3'd0, 3'd0, 0);
      bus.task_start = 1'b1;
      tick();
      n = 0;
      while (starts.size() == 0 && n < 20) begin tick(); n++; end
      tick(); tick(); tick();
      bus.engine_done = 4'b0010;
      tick();
      vectors++; if (bus.busy !== 1'b1 || bus.pop_order_en !== 1'b0) begin miscompares++; $display("FAIL abort_other_done_ignored: got busy=%b pop=%b want 1/0", bus.busy, bus.pop_order_en); end
      bus.abort       = 1'b1;
      bus.engine_done = 4'b0001;
      tick();
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
      vectors++; if (bus.pop_order_en !== 1'b0 || bus.task_done !== 1'b0) begin miscompares++; $display("FAIL abort_no_pop_done: got pop=%b done=%b want 0/0", bus.pop_order_en, bus.task_done); end
      vectors++; if (bus.active_order !== 3'd0) begin miscompares++; $display("FAIL abort_active: got %0d want 0", bus.active_order); end
      repeat (3) tick();
      vectors++; if (pops != 1 || done_cnt != 0) begin miscompares++; $display("FAIL abort_quiet: got pops=%0d done=%0d want 1/0", pops, done_cnt); end
      prep(3'd2, 3'd5, 3'd0, 3'd0, 3'd0, 10);
      bus.task_start = 1'b1;
      tick();
      tick();
      vectors++; if (bus.order_count !== 10'd1) begin miscompares++; $display("FAIL abort_restart_count: got %0d want 1", bus.order_count); end
      n = 0;
      while (done_cnt == 0 && n < 200) begin tick(); n++; end
      vectors++; if (done_cnt != 1 || bus.order_count !== 10'd2) begin miscompares++; $display("FAIL abort_restart_finish: got done=%0d count=%0d want 1/2", done_cnt, bus.order_count); end
      tick();
   endtask

   task automatic test_start_abort_idle();
      prep(3'd1, 3'd5, 3'd0, 3'd0, 3'd0, 10);
      bus.task_start = 1'b1;
      bus.abort      = 1'b1;
      tick();
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL idle_abort_busy: got %b want 0", bus.busy); end
      tick(); tick();
      vectors++; if (pops != 0) begin miscompares++; $display("FAIL idle_abort_pops: got %0d want 0", pops); end
   endtask

   task automatic test_overflow();
      int n;
      prep(3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 10);
      bus.task_start = 1'b1;
      tick();
      n = 0;
      while (starts.size() == 0 && n < 20) begin tick(); n++; end
      tick();
      bus.task_start = 1'b1;
      tick();
      vectors++; if (bus.busy !== 1'b1 || bus.order_count !== 10'd1) begin miscompares++; $display("FAIL overflow_start_ignored: got busy=%b count=%0d want 1/1", bus.busy, bus.order_count); end
      n = 0;
      while (!bus.task_error && n < 300) begin tick(); n++; end
      vectors++; if (bus.error_code !== ERR_PROTOCOL) begin miscompares++; $display("FAIL overflow_code: got %0d want 3", bus.error_code); end
      vectors++; if (pops != 4 || bus.order_count !== 10'd4) begin miscompares++; $display("FAIL overflow_pops: got pops=%0d count=%0d want 4/4", pops, bus.order_count); end
      vectors++; if (starts.size() != 4 || done_cnt != 0) begin miscompares++; $display("FAIL overflow_starts: got starts=%0d done=%0d want 4/0", starts.size(), done_cnt); end
      bus.abort = 1'b1;
      tick();
   endtask

   task automatic test_missing_calc();
      int n;
      prep(3'd1, 3'd5, 3'd0, 3'd0, 3'd0, 10);
      suppress_cal   = 1'b1;
      bus.task_start = 1'b1;
      tick();
      n = 0;
      while (!bus.task_error && n < 50) begin tick(); n++; end
      vectors++; if (bus.error_code !== ERR_PROTOCOL) begin miscompares++; $display("FAIL nocalc_code: got %0d want 3", bus.error_code); end
      vectors++; if (pops != 1 || starts.size() != 0) begin miscompares++; $display("FAIL nocalc_activity: got pops=%0d starts=%0d want 1/0", pops, starts.size()); end
      bus.abort    = 1'b1;
      suppress_cal = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_run();
      int n;
      prep(3'd4, 3'd5, 3'd0, 3'd0, 3'd0, 0);
      bus.task_start = 1'b1;
      tick();
      n = 0;
      while (starts.size() == 0 && n < 20) begin tick(); n++; end
      vectors++; if (bus.engine_start !== 4'b1000) begin miscompares++; $display("FAIL midrst_start: got %b want 1000", bus.engine_start); end
      tick(); tick();
      rst = 1'b1;
      tick();
      vectors++; if (bus.busy !== 1'b0 || bus.pop_order_en !== 1'b0 || bus.engine_start !== 4'b0000) begin miscompares++; $display("FAIL midrst_ctrl: got busy=%b pop=%b start=%b want 0/0/0000", bus.busy, bus.pop_order_en, bus.engine_start); end
      vectors++; if (bus.active_order !== 3'd0 || bus.order_count !== 10'd0) begin miscompares++; $display("FAIL midrst_status: got active=%0d count=%0d want 0/0", bus.active_order, bus.order_count); end
      vectors++; if (bus.task_done !== 1'b0 || bus.task_error !== 1'b0 || bus.error_code !== 2'd0) begin miscompares++; $display("FAIL midrst_flags: got done=%b err=%b code=%0d want 0/0/0", bus.task_done, bus.task_error, bus.error_code); end
      rst = 1'b0;
      tick();
   endtask

   initial begin
      bus.task_start      = 1'b0;
      bus.abort           = 1'b0;
      bus.calculate_start = 1'b0;
      bus.order           = 3'd0;
      bus.engine_done     = 4'b0000;
      cyc = 0; start_cyc = 0; eng_bit = 4'b0000;
      prep(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 0);
      test_reset();
      test_basic_list();
      test_illegal_opcode();
      test_timeout();
      test_abort_race();
      test_start_abort_idle();
      test_overflow();
      test_missing_calc();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit: got no finish want finish before 1ms");
      $fatal(1);
   end

endmodule

// File: doc/order_dispatcher.md
ORDER_DISPATCHER -- requirements
Module: order_dispatcher

Interface
REQ-001 Parameter MAX_ORDERS, default 512, pops allowed per task before overflow error (matches 9-bit order cache depth).
REQ-002 Parameter TIMEOUT_CYCLES, default 2^24-1, max system_clk cycles an engine may run before timeout error.
REQ-003 system_clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 task_start  input  1  one-cycle request to execute the cached order list from its head.
REQ-006 abort  input  1  one-cycle request to stop the current task.
REQ-007 pop_order_en  output  1  one-cycle pop strobe to the order cache.
REQ-008 calculate_start  input  1  cache strobe, high exactly one cycle after pop_order_en; order fields valid that cycle.
REQ-009 order  input  3  opcode from cache: 1 conv, 2 pool, 3 upsample, 4 add, 5 end; 0/6/7 illegal.
REQ-010 engine_start  output  4  one-hot one-cycle start; bit (order-1) selects the engine.
REQ-011 engine_done  input  4  one-cycle completion pulse per engine.
REQ-012 active_order  output  3  opcode currently executing; 0 when none.
REQ-013 order_count  output  10  orders popped in the current task, including the end order.
REQ-014 busy  output  1  high from task acceptance until return to IDLE or ERROR.
REQ-015 task_done  output  1  one-cycle pulse when order 5 is reached.
REQ-016 task_error  output  1  sticky error flag; error_code  output  2: 1 illegal opcode, 2 timeout, 3 overflow or missing calculate_start.

Function
REQ-017 States SHALL be IDLE, POP, LOAD, ISSUE, RUN, FINISH, ERROR.
REQ-018 IDLE: task_start -> POP; order_count cleared to 0 the same edge; busy rises next cycle.
REQ-019 POP: pop_order_en=1 for exactly one cycle; order_count increments; -> LOAD.
REQ-020 LOAD (one cycle): calculate_start=0 -> ERROR code 3; order=5 -> FINISH; order 1..4 -> ISSUE with active_order latched; else ERROR code 1.
REQ-021 ISSUE: engine_start[active_order-1]=1 for one cycle; watchdog cleared; -> RUN.
REQ-022 RUN: engine_done[active_order-1] -> POP, or ERROR code 3 if order_count==MAX_ORDERS; done bits of other engines ignored.
REQ-023 RUN: watchdog reaching TIMEOUT_CYCLES without done -> ERROR code 2.
REQ-024 Minimum pop-to-pop spacing SHALL be 4 cycles (POP, LOAD, ISSUE, RUN), satisfying the cache's synchronous RAM read latency.
REQ-025 FINISH: task_done=1 for one cycle; active_order=0; -> IDLE.
REQ-026 ERROR: task_error=1, busy=0, no pops or starts; exit only via abort or rst -> IDLE, clearing task_error and error_code.
REQ-027 task_start outside IDLE SHALL be ignored.
REQ-028 abort in any non-IDLE state SHALL force IDLE next edge; active_order=0; no task_done pulse; abort wins over a same-cycle engine_done.
REQ-029 task_start and abort in the same IDLE cycle: abort wins, and the task is not started.
REQ-030 order_count SHALL saturate and never wrap; watchdog SHALL saturate.

Reset
REQ-031 On rst: state IDLE; pop_order_en, engine_start, task_done, task_error, busy = 0; active_order, order_count, error_code, watchdog = 0.
REQ-032 rst mid-task SHALL drop engine_start and pop_order_en in the same edge; cache read pointer is not this block's responsibility.

Structure
REQ-033 Opcode constants (ORD_CONV..ORD_END) and error codes SHALL reside in the shared parameters include; state encoding stays local.
REQ-034 The timeout counter SHALL be one sub-module, order_watchdog (clear, enable, expired).

Verification
REQ-035 List {1,2,5}, engines done 10 cycles after start -> starts 0001 then 0010, task_done once, order_count=3, three pops.
REQ-036 List {3,0} -> engine_start 0100, then ERROR with error_code=1, task_error held, no further pop.
REQ-037 List {1}, TIMEOUT_CYCLES=100, engine never done -> error_code=2 after 100 RUN cycles, busy=0.
REQ-038 Abort in RUN on the same cycle as engine_done -> IDLE, no pop, no task_done; a subsequent task_start restarts with order_count=1 after the first pop.
REQ-039 MAX_ORDERS=4, list of five conv orders -> error_code=3 after the 4th done; task_start during the run ignored.
REQ-040 calculate_start suppressed in LOAD -> error_code=3; rst mid-RUN -> all outputs 0 next cycle.
